// File: rtl/qe_operand_feeder_pkg.sv
// Shared types and constants for the quadratic-evaluator operand feeder.
package qe_operand_feeder_pkg;

    localparam int unsigned DEFAULT_DEPTH   = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 64;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned RES_W           = 16;
    localparam int unsigned CNT_W           = 8;

    localparam logic MODE_QE = 1'b0;
    localparam logic MODE_PS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One FIFO entry: three coefficients, the operand and the stream terminator.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] x;
        logic              last;
    } tuple_t;

endpackage

// File: rtl/qe_tuple_fifo.sv
// Operand tuple FIFO; a push while full is dropped even if a pop happens the same cycle.
module qe_tuple_fifo
    import qe_operand_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  tuple_t push_data,
    input  logic   pop,
    output tuple_t pop_data,
    output logic   empty_c,
    output logic   full_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    tuple_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full_c   = (count == CW'(DEPTH));
    assign empty_c  = (count == '0);
    assign do_push  = push && !full_c;
    assign do_pop   = pop && !empty_c;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/qe_operand_feeder.sv
// Feeds buffered operand tuples to an external MAC and captures its result with a timeout.
module qe_operand_feeder
    import qe_operand_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic [DATA_W-1:0] wr_c,
    input  logic [DATA_W-1:0] wr_x,
    input  logic              wr_last,
    output logic              full,
    input  logic              start,
    input  logic              start_mode,
    output logic              busy,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic [DATA_W-1:0] mac_c,
    output logic [DATA_W-1:0] mac_x,
    output logic              mac_mode,
    output logic              mac_valid_in,
    output logic              mac_last,
    input  logic              mac_valid_out,
    input  logic [RES_W-1:0]  mac_result,
    output logic              res_valid,
    output logic [RES_W-1:0]  res_data,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_nx;

    tuple_t             wr_tuple;
    tuple_t             fifo_head;
    logic               fifo_pop_c;
    logic               fifo_empty_c;
    logic               fifo_full_c;

    logic               busy_nx;
    logic [DATA_W-1:0]  mac_a_nx, mac_b_nx, mac_c_nx, mac_x_nx;
    logic               mac_mode_nx, mac_valid_in_nx, mac_last_nx;
    logic               res_valid_nx, timeout_err_nx;
    logic [RES_W-1:0]   res_data_nx;

    assign wr_tuple = {wr_a, wr_b, wr_c, wr_x, wr_last};
    assign full     = fifo_full_c;

    qe_tuple_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_tuple),
        .pop       (fifo_pop_c),
        .pop_data  (fifo_head),
        .empty_c   (fifo_empty_c),
        .full_c    (fifo_full_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start && !fifo_empty_c) state_nx = ST_ISSUE;
            ST_ISSUE: if (!fifo_empty_c && (mac_mode == MODE_QE || fifo_head.last))
                          state_nx = ST_WAIT;
            ST_WAIT:  if (mac_valid_out || wait_cnt == TMO_LAST) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Operand/result registers hold unless this state updates them; pulses default low.
    always_comb begin
        fifo_pop_c      = 1'b0;
        wait_cnt_nx     = '0;
        busy_nx         = (state_nx != ST_IDLE);
        mac_a_nx        = mac_a;
        mac_b_nx        = mac_b;
        mac_c_nx        = mac_c;
        mac_x_nx        = mac_x;
        mac_mode_nx     = mac_mode;
        mac_valid_in_nx = 1'b0;
        mac_last_nx     = mac_last;
        res_valid_nx    = 1'b0;
        res_data_nx     = res_data;
        timeout_err_nx  = timeout_err;
        case (state)
            ST_IDLE: begin
                if (start && !fifo_empty_c) begin
                    mac_mode_nx    = start_mode;
                    timeout_err_nx = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (!fifo_empty_c) begin
                    fifo_pop_c      = 1'b1;
                    mac_a_nx        = fifo_head.a;
                    mac_b_nx        = fifo_head.b;
                    mac_c_nx        = fifo_head.c;
                    mac_x_nx        = fifo_head.x;
                    mac_valid_in_nx = 1'b1;
                    mac_last_nx     = (mac_mode == MODE_PS) && fifo_head.last;
                end
            end
            ST_WAIT: begin
                if (mac_valid_out) begin
                    res_data_nx  = mac_result;
                    res_valid_nx = 1'b1;
                end else if (wait_cnt == TMO_LAST) begin
                    timeout_err_nx = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt     <= '0;
            busy         <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_c        <= '0;
            mac_x        <= '0;
            mac_mode     <= MODE_QE;
            mac_valid_in <= 1'b0;
            mac_last     <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            wait_cnt     <= wait_cnt_nx;
            busy         <= busy_nx;
            mac_a        <= mac_a_nx;
            mac_b        <= mac_b_nx;
            mac_c        <= mac_c_nx;
            mac_x        <= mac_x_nx;
            mac_mode     <= mac_mode_nx;
            mac_valid_in <= mac_valid_in_nx;
            mac_last     <= mac_last_nx;
            res_valid    <= res_valid_nx;
            res_data     <= res_data_nx;
            timeout_err  <= timeout_err_nx;
        end
    end

endmodule

// File: tb/tb_qe_operand_feeder.sv
// Scoreboard bench for qe_operand_feeder: tuples and results queued on drive, checked on output.
module tb_qe_operand_feeder;
    import qe_operand_feeder_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_a = '0, wr_b = '0, wr_c = '0, wr_x = '0;
    logic        wr_last = 1'b0;
    logic        full;
    logic        start = 1'b0;
    logic        start_mode = 1'b0;
    logic        busy;
    logic [7:0]  mac_a, mac_b, mac_c, mac_x;
    logic        mac_mode, mac_valid_in, mac_last;
    logic        mac_valid_out = 1'b0;
    logic [15:0] mac_result = '0;
    logic        res_valid;
    logic [15:0] res_data;
    logic        timeout_err;

    qe_operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .wr_c(wr_c), .wr_x(wr_x), .wr_last(wr_last),
        .full(full), .start(start), .start_mode(start_mode), .busy(busy),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_x(mac_x),
        .mac_mode(mac_mode), .mac_valid_in(mac_valid_in), .mac_last(mac_last),
        .mac_valid_out(mac_valid_out), .mac_result(mac_result),
        .res_valid(res_valid), .res_data(res_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    tuple_t      exp_q[$];
    logic [15:0] res_q[$];
    int          vi_cyc[$];
    int          n_cmp = 0, n_err = 0;
    int          n_vi = 0, n_res = 0, cyc = 0, mcount = 0;
    logic        cur_mode = MODE_QE;
    tuple_t      mon_t;
    logic        mon_last;
    logic [15:0] mon_res;

    // Output monitor: every MAC issue and every result pulse is checked against the scoreboard.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (reset) begin
            if (mac_valid_in) begin
                n_vi++;
                vi_cyc.push_back(cyc);
                if (mcount > 0) mcount--;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_unexpected: mac_valid_in=1 got, none queued required");
                end else begin
                    mon_t = exp_q.pop_front();
                    mon_last = (cur_mode == MODE_PS) ? mon_t.last : 1'b0;
                    if ({mac_a, mac_b, mac_c, mac_x, mac_last, mac_mode} !==
                        {mon_t.a, mon_t.b, mon_t.c, mon_t.x, mon_last, cur_mode}) begin
                        n_err++;
                        $display("FAIL issue_data: got %h %h %h %h last=%b mode=%b, need %h %h %h %h last=%b mode=%b",
                                 mac_a, mac_b, mac_c, mac_x, mac_last, mac_mode,
                                 mon_t.a, mon_t.b, mon_t.c, mon_t.x, mon_last, cur_mode);
                    end
                end
            end
            if (res_valid) begin
                n_res++;
                n_cmp++;
                if (res_q.size() == 0) begin
                    n_err++;
                    $display("FAIL res_unexpected: res_valid=1 data=%h got, no pulse required", res_data);
                end else begin
                    mon_res = res_q.pop_front();
                    if (res_data !== mon_res) begin
                        n_err++;
                        $display("FAIL res_data: got %h need %h", res_data, mon_res);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [7:0] a, b, c, x, input logic last);
        @(negedge clk);
        wr_en = 1'b1; wr_a = a; wr_b = b; wr_c = c; wr_x = x; wr_last = last;
        if (mcount < DEPTH) begin
            exp_q.push_back({a, b, c, x, last});
            mcount++;
        end
    endtask

    task automatic end_push();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_txn(input logic mode);
        @(negedge clk);
        start = 1'b1; start_mode = mode; cur_mode = mode;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic respond(input logic [15:0] r);
        @(negedge clk);
        mac_valid_out = 1'b1; mac_result = r;
        res_q.push_back(r);
        @(negedge clk);
        mac_valid_out = 1'b0;
    endtask

    task automatic wait_vi(input int target, input int budget);
        int k = 0;
        while (n_vi < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (n_vi < target) begin
            n_err++;
            $display("FAIL wait_valid_in: got %0d issues, need %0d", n_vi, target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, full, mac_valid_in, mac_last, mac_mode, res_valid, timeout_err} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b need 0000000",
                     {busy, full, mac_valid_in, mac_last, mac_mode, res_valid, timeout_err});
        end
        n_cmp++;
        if ({mac_a, mac_b, mac_c, mac_x, res_data} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h need 0", {mac_a, mac_b, mac_c, mac_x, res_data});
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, full} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release: busy/full got %b need 00", {busy, full});
        end
    endtask

    task automatic test_quadratic();
        int b_vi = n_vi, b_res = n_res;
        push(8'd2, 8'd3, 8'd1, 8'd4, 1'b0);
        end_push();
        start_txn(MODE_QE);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL qe_busy_rise: got %b need 1", busy); end
        wait_vi(b_vi + 1, 20);
        repeat (2) @(negedge clk);
        respond(16'd45);
        n_cmp++;
        if ({res_valid, busy} !== 2'b11) begin
            n_err++; $display("FAIL qe_done: res_valid/busy got %b need 11", {res_valid, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({res_valid, busy, res_data} !== {2'b00, 16'd45}) begin
            n_err++; $display("FAIL qe_after: got %b/%0d need 00/45", {res_valid, busy}, res_data);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_vi - b_vi != 1 || n_res - b_res != 1 || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL qe_counts: issues %0d results %0d terr %b need 1 1 0",
                              n_vi - b_vi, n_res - b_res, timeout_err);
        end
    endtask

    task automatic test_product_sum();
        int b_vi = n_vi;
        vi_cyc.delete();
        push(8'h11, 8'h12, 8'h13, 8'h14, 1'b0);
        push(8'h21, 8'h22, 8'h23, 8'h24, 1'b0);
        push(8'h31, 8'h32, 8'h33, 8'h34, 1'b0);
        push(8'h41, 8'h42, 8'h43, 8'h44, 1'b1);
        end_push();
        start_txn(MODE_PS);
        wait_vi(b_vi + 4, 20);
        n_cmp++;
        if (vi_cyc.size() < 4 || vi_cyc[3] - vi_cyc[0] != 3) begin
            n_err++; $display("FAIL ps_back_to_back: span got %0d need 3",
                              (vi_cyc.size() < 4) ? -1 : vi_cyc[3] - vi_cyc[0]);
        end
        respond(16'h1234);
        n_cmp++;
        if (res_valid !== 1'b1) begin n_err++; $display("FAIL ps_res_valid: got %b need 1", res_valid); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL ps_end: busy %b pending %0d need 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int b_vi = n_vi;
        vi_cyc.delete();
        push(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        push(8'd5, 8'd6, 8'd7, 8'd8, 1'b0);
        end_push();
        start_txn(MODE_PS);
        wait_vi(b_vi + 2, 20);
        repeat (TIMEOUT + 4) @(negedge clk);
        n_cmp++;
        if ({busy, timeout_err} !== 2'b10 || n_vi != b_vi + 2) begin
            n_err++; $display("FAIL stall_hold: busy/terr %b issues %0d need 10 %0d",
                              {busy, timeout_err}, n_vi - b_vi, 2);
        end
        push(8'd9, 8'd10, 8'd11, 8'd12, 1'b1);
        end_push();
        wait_vi(b_vi + 3, 10);
        n_cmp++;
        if (vi_cyc.size() < 3 || vi_cyc[2] - vi_cyc[1] <= int'(TIMEOUT)) begin
            n_err++; $display("FAIL stall_gap: gap got %0d need > %0d",
                              (vi_cyc.size() < 3) ? -1 : vi_cyc[2] - vi_cyc[1], TIMEOUT);
        end
        respond(16'h0777);
        n_cmp++;
        if ({res_valid, timeout_err} !== 2'b10) begin
            n_err++; $display("FAIL stall_result: res_valid/terr got %b need 10", {res_valid, timeout_err});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full();
        int b_vi = n_vi;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48), (i >= DEPTH - 1) ? 1'b1 : 1'b0);
            if (i == DEPTH - 1 || i == DEPTH) begin
                n_cmp++;
                if (full !== ((i == DEPTH) ? 1'b1 : 1'b0)) begin
                    n_err++; $display("FAIL full_flag: after %0d pushes got %b need %b",
                                      i, full, (i == DEPTH));
                end
            end
        end
        end_push();
        n_cmp++;
        if (full !== 1'b1) begin n_err++; $display("FAIL full_hold: got %b need 1", full); end
        start_txn(MODE_PS);
        wait_vi(b_vi + DEPTH, 30);
        respond(16'h00AA);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (full !== 1'b0) begin n_err++; $display("FAIL full_drain: got %b need 0", full); end
        start_txn(MODE_QE);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL empty_start: busy got %b need 0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_vi != b_vi + DEPTH) begin
            n_err++; $display("FAIL full_drop: issues got %0d need %0d", n_vi - b_vi, DEPTH);
        end
    endtask

    task automatic test_timeout();
        int b_vi = n_vi, b_res = n_res, k = 0;
        push(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        end_push();
        start_txn(MODE_QE);
        wait_vi(b_vi + 1, 20);
        while (timeout_err !== 1'b1 && k < TIMEOUT + 5) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b need 1", timeout_err); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || n_res != b_res) begin
            n_err++; $display("FAIL timeout_end: busy %b results %0d need 0 0", busy, n_res - b_res);
        end
        push(8'd2, 8'd0, 8'd0, 8'd1, 1'b0);
        end_push();
        start_txn(MODE_QE);
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b need 0", timeout_err); end
        wait_vi(b_vi + 2, 20);
        repeat (TIMEOUT - 2) @(negedge clk);
        respond(16'd2);
        n_cmp++;
        if ({res_valid, timeout_err} !== 2'b10) begin
            n_err++; $display("FAIL timeout_tie: res_valid/terr got %b need 10", {res_valid, timeout_err});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int b_vi = n_vi, b_res;
        push(8'd3, 8'd3, 8'd3, 8'd3, 1'b0);
        push(8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
        end_push();
        start_txn(MODE_QE);
        wait_vi(b_vi + 1, 20);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, full, mac_valid_in, mac_last, mac_mode, res_valid, timeout_err} !== 7'b0) begin
            n_err++; $display("FAIL midreset_flags: got %b need 0000000",
                              {busy, full, mac_valid_in, mac_last, mac_mode, res_valid, timeout_err});
        end
        n_cmp++;
        if ({mac_a, mac_b, mac_c, mac_x, res_data} !== 48'h0) begin
            n_err++; $display("FAIL midreset_data: got %h need 0", {mac_a, mac_b, mac_c, mac_x, res_data});
        end
        exp_q.delete(); res_q.delete(); mcount = 0;
        b_res = n_res;
        mac_valid_out = 1'b1; mac_result = 16'hBEEF;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        mac_valid_out = 1'b0;
        n_cmp++;
        if (n_res != b_res || res_data !== 16'h0) begin
            n_err++; $display("FAIL midreset_late: results %0d data %h need 0 0000", n_res - b_res, res_data);
        end
        start_txn(MODE_QE);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_fifo: busy got %b need 0", busy); end
        b_vi = n_vi;
        push(8'd2, 8'd3, 8'd1, 8'd4, 1'b0);
        end_push();
        start_txn(MODE_QE);
        wait_vi(b_vi + 1, 20);
        respond(16'd45);
        n_cmp++;
        if ({res_valid, res_data} !== {1'b1, 16'd45}) begin
            n_err++; $display("FAIL midreset_rerun: got %b/%0d need 1/45", res_valid, res_data);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_quadratic();
        test_product_sum();
        test_stall();
        test_full();
        test_timeout();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0 || res_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: pending tuples %0d results %0d need 0 0",
                              exp_q.size(), res_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
